ps2_keycode_decoder: RTL
========================

// Module: ps2_keycode_decoder
// PURPOSE
//   Stateful PS/2 set-2 scancode decoder. Takes the raw scancode byte stream from the PS/2 receiver.
//   Tracks break (F0) and extended (E0) prefixes, Shift and Caps Lock state.
//   Emits ASCII characters through a buffered valid/ready FIFO to the downstream text/UART consumer.
//   Replaces the stateless lookup: key releases, lowercase, control keys and back-pressure are all handled here.
// PARAMETERS
//   FIFO_DEPTH  8  output character FIFO entries; power of 2, >= 2
//   LOWER_EN    1  1: letters are lowercase unless Shift XOR Caps; 0: letters are always uppercase
//   CTRL_EN     1  1: map Space, Enter and Backspace; 0: drop them
// PORTS
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   code_valid   in   1  code_in holds a new scancode byte; one-cycle strobe
//   code_in      in   8  scancode byte from the PS/2 receiver
//   ascii_valid  out  1  FIFO not empty; ascii_out is valid
//   ascii_out    out  8  ASCII character at the FIFO head
//   ascii_ready  in   1  consumer pops the head when ascii_valid && ascii_ready
//   shift_o      out  1  current Shift state: left OR right Shift held
//   caps_o       out  1  current Caps Lock toggle state
//   overflow     out  1  sticky; a character was dropped because the FIFO was full
//   ovf_clr      in   1  clears overflow; set wins if it coincides with a new drop
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - FSM to IDLE; FIFO empty; lookup stage empty.
//     - ascii_valid=0, ascii_out=0, shift_o=0, caps_o=0, overflow=0.
//     - Mid-stream reset discards a pending prefix and all buffered characters.
//   FSM: one transition per code_valid cycle; no change while code_valid=0.
//     - IDLE:     F0 -> BRK; E0 -> EXT; other -> make(code), stay IDLE.
//     - BRK:      any -> break(code) -> IDLE.
//     - EXT:      F0 -> EXT_BRK; other -> dropped (extended make) -> IDLE.
//     - EXT_BRK:  any -> dropped -> IDLE.
//     - A repeated E0/F0 in a prefix state follows the same table (e.g. EXT+E0 -> IDLE, dropped).
//   make(code)
//     - 12 (L-shift) / 59 (R-shift): set that shift flag; no character.
//     - 58 (Caps Lock): toggle caps_o; no character. Typematic repeats also toggle.
//     - Letter 1C..1A, set-2 A-Z table: upper 41..5A when (shift XOR caps) or LOWER_EN=0, else lower 61..7A.
//     - Digits 45,16,1E,26,25,2E,36,3D,3E,46 -> 30..39. Shift does not alter digits.
//     - CTRL_EN=1: 29 -> 20 (Space), 5A -> 0D (Enter), 66 -> 08 (Backspace).
//     - Any unlisted code: dropped; no output, no state change. Never re-emits the previous character.
//   break(code)
//     - Releasing 12 or 59 clears the matching shift flag. All other breaks produce no output.
//   Pipeline and latency
//     - The mapped character is registered at edge E (edge that samples code_valid).
//     - It is written into the FIFO at E+1; ascii_valid=1 from E+1 if the FIFO was empty.
//     - Latency is 2 edges to an empty FIFO.
//     - Shift/caps updates are visible on shift_o/caps_o after edge E.
//     - The shift/caps state in effect before E applies to the code at E.
//   FIFO
//     - Pop occurs when ascii_valid && ascii_ready.
//     - Pointers wrap modulo FIFO_DEPTH; the count is log2(DEPTH)+1 bits.
//     - Write while full with no pop: character dropped, overflow set, FIFO contents unchanged.
//     - Write and pop in the same cycle while full: both succeed and the count is unchanged.
//     - Write and pop in the same cycle while empty: impossible, since ascii_valid=0.
//     - ascii_out is held stable while ascii_valid && !ascii_ready.
// STRUCTURE
//   Package ps2_kbd_pkg
//     - Scancode constants: PS2_BRK=F0, PS2_EXT=E0, PS2_LSHIFT=12, PS2_RSHIFT=59, PS2_CAPS=58.
//     - FSM state encoding: IDLE, BRK, EXT, EXT_BRK.
//     - Function map_code(code, upper, ctrl_en) returning {hit, ascii[7:0]}.
//   Sub-module ps2_char_fifo
//     - Parametrised synchronous FIFO with valid/ready read side and full/write/drop flags.
//   Top level: FSM, modifier registers, lookup stage, overflow flag.
// TESTING
//   1. Reset, then code 1C -> one char 61 ('a') after 2 edges. Then F0,1C -> no char.
//   2. Sequence 12,1C,F0,12,1C -> chars 41 then 61; shift_o is 1 then 0.
//   3. Sequence 58,F0,58,32,12,32 -> caps_o=1; chars 42 then 62 (Shift XOR Caps).
//   4. Hold ascii_ready=0 and send FIFO_DEPTH+1 codes of 16 -> 8 x 31, overflow=1.
//      Then pulse ovf_clr -> overflow=0; drain returns exactly 8 chars.
//   5. Full FIFO with ascii_ready=1 and a new code in the same cycle -> no drop, count stays 8.
//   6. Send E0 then rst_n low mid-stream, then 45 -> outputs cleared; char 30 follows, not treated as extended.
//      Sequence E0,75,E0,F0,75,1B -> only 73.

Source files
------------

// File: rtl/ps2_keycode_decoder_pkg.sv
// Shared constants, FSM encoding and scancode-to-ASCII lookup for the PS/2 set-2 decoder.
package ps2_kbd_pkg;

   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_LSHIFT = 8'h12;
   localparam logic [7:0] PS2_RSHIFT = 8'h59;
   localparam logic [7:0] PS2_CAPS   = 8'h58;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } ps2_state_e;

   // Returns {hit, ascii}. Letters are resolved to an alphabet index first so the
   // case selection is applied with a single add.
   function automatic logic [8:0] map_code(input logic [7:0] code,
                                           input logic       upper,
                                           input logic       ctrl_en);
      logic [4:0] idx;
      logic       is_letter;
      logic [8:0] res;
      idx       = 5'd0;
      is_letter = 1'b1;
      res       = 9'd0;
      case (code)
         8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;
         8'h23: idx = 5'd3;   8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;
         8'h34: idx = 5'd6;   8'h33: idx = 5'd7;   8'h43: idx = 5'd8;
         8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
         8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;
         8'h4D: idx = 5'd15;  8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;
         8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;  8'h3C: idx = 5'd20;
         8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
         8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
         default: is_letter = 1'b0;
      endcase
      if (is_letter) begin
         res = {1'b1, (upper ? 8'h41 : 8'h61) + {3'b000, idx}};
      end else begin
         case (code)
            8'h45: res = {1'b1, 8'h30};
            8'h16: res = {1'b1, 8'h31};
            8'h1E: res = {1'b1, 8'h32};
            8'h26: res = {1'b1, 8'h33};
            8'h25: res = {1'b1, 8'h34};
            8'h2E: res = {1'b1, 8'h35};
            8'h36: res = {1'b1, 8'h36};
            8'h3D: res = {1'b1, 8'h37};
            8'h3E: res = {1'b1, 8'h38};
            8'h46: res = {1'b1, 8'h39};
            8'h29: res = ctrl_en ? {1'b1, 8'h20} : 9'd0;
            8'h5A: res = ctrl_en ? {1'b1, 8'h0D} : 9'd0;
            8'h66: res = ctrl_en ? {1'b1, 8'h08} : 9'd0;
            default: res = 9'd0;
         endcase
      end
      return res;
   endfunction

endpackage

// File: rtl/ps2_keycode_decoder_if.sv
// Scancode input stream, ASCII output stream and status signals of the keycode decoder.
interface ps2_keycode_decoder_if;
   logic       code_valid;
   logic [7:0] code_in;
   logic       ascii_valid;
   logic [7:0] ascii_out;
   logic       ascii_ready;
   logic       shift_o;
   logic       caps_o;
   logic       overflow;
   logic       ovf_clr;

   modport master (
      output code_valid, code_in, ascii_ready, ovf_clr,
      input  ascii_valid, ascii_out, shift_o, caps_o, overflow
   );

   modport slave (
      input  code_valid, code_in, ascii_ready, ovf_clr,
      output ascii_valid, ascii_out, shift_o, caps_o, overflow
   );
endinterface

// File: rtl/ps2_keycode_decoder_fifo.sv
// Character FIFO: valid/ready read side, drops writes that arrive while full with no pop.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module ps2_char_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              rd_ready,
   output logic              full,
   output logic              drop
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              pop;
   logic              push;

   assign rd_valid = (count != '0);
   assign full     = (count == CNT_FULL);
   assign pop      = rd_valid && rd_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
   assign push     = wr_en && (!full || pop);
   assign drop     = wr_en && full && !pop;
   // Head is forced to zero when empty so the output is defined without resetting storage.
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Character storage; contents are only meaningful behind the occupancy count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 set-2 scancode decoder: prefix FSM, Shift/Caps tracking, one-stage
// lookup register feeding a buffered ASCII character FIFO.
module ps2_keycode_decoder
   import ps2_kbd_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter bit LOWER_EN   = 1'b1,
   parameter bit CTRL_EN    = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   ps2_keycode_decoder_if.slave bus
);

   ps2_state_e st_q;
   ps2_state_e st_d;
   logic       is_make;
   logic       is_brk;
   logic       lshift_q;
   logic       rshift_q;
   logic       caps_q;
   logic       upper;
   logic [8:0] map_r;
   logic       vld_p0;
   logic [7:0] char_p0;
   logic       fifo_full;
   logic       fifo_drop;
   logic       ovf_q;

   // Prefix state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st_q <= IDLE;
      else        st_q <= st_d;
   end

   // Next prefix state and classification of the incoming byte as make or break.
   always_comb begin
      st_d    = st_q;
      is_make = 1'b0;
      is_brk  = 1'b0;
      if (bus.code_valid) begin
         case (st_q)
            IDLE: begin
               if (bus.code_in == PS2_BRK)      st_d = BRK;
               else if (bus.code_in == PS2_EXT) st_d = EXT;
               else                             is_make = 1'b1;
            end
            BRK: begin
               is_brk = 1'b1;
               st_d   = IDLE;
            end
            EXT:     st_d = (bus.code_in == PS2_BRK) ? EXT_BRK : IDLE;
            EXT_BRK: st_d = IDLE;
            default: st_d = IDLE;
         endcase
      end
   end

   // Shift flags follow make/release; Caps Lock toggles on every make, repeats included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lshift_q <= 1'b0;
         rshift_q <= 1'b0;
         caps_q   <= 1'b0;
      end else if (is_make) begin
         if (bus.code_in == PS2_LSHIFT) lshift_q <= 1'b1;
         if (bus.code_in == PS2_RSHIFT) rshift_q <= 1'b1;
         if (bus.code_in == PS2_CAPS)   caps_q   <= ~caps_q;
      end else if (is_brk) begin
         if (bus.code_in == PS2_LSHIFT) lshift_q <= 1'b0;
         if (bus.code_in == PS2_RSHIFT) rshift_q <= 1'b0;
      end
   end

   // Lookup uses the modifier state from before this edge.
   assign upper = !LOWER_EN || ((lshift_q | rshift_q) ^ caps_q);
   assign map_r = map_code(bus.code_in, upper, CTRL_EN);

   // ---- stage p0: mapped character registered at the sampling edge ----
   // Lookup valid; only mapped make codes produce a character.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_p0 <= 1'b0;
      else        vld_p0 <= is_make && map_r[8];
   end

   // Lookup data, qualified by vld_p0.
   always_ff @(posedge clk) begin
      char_p0 <= map_r[7:0];
   end

   // ---- stage p1: character written into the FIFO ----
   ps2_char_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (8)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (vld_p0),
      .wr_data  (char_p0),
      .rd_valid (bus.ascii_valid),
      .rd_data  (bus.ascii_out),
      .rd_ready (bus.ascii_ready),
      .full     (fifo_full),
      .drop     (fifo_drop)
   );

   // Sticky overflow; a new drop outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           ovf_q <= 1'b0;
      else if (fifo_drop)   ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
   end

   assign bus.shift_o  = lshift_q | rshift_q;
   assign bus.caps_o   = caps_q;
   assign bus.overflow = ovf_q;

endmodule
